// File: rtl/vcve2_vrf_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : vcve2_vrf_obi_responder
// Description : OBI data-port responder backed by a flop-based vector
//               register file image. Grant may be delayed by a fixed
//               number of request cycles. Responses arrive one cycle after
//               each handshake and never stall.
// Revision    : 1.0 - initial release
// ============================================================================
module vcve2_vrf_obi_responder #(
   parameter int unsigned VLEN     = 128,
   parameter int unsigned NumVRegs = 32,
   parameter logic [31:0] BaseAddr = 32'h0000_0000,
   parameter int unsigned GntWait  = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        busy_o
);

   localparam int unsigned NumWords   = NumVRegs * VLEN / 32;
   localparam int unsigned IdxW       = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam logic [31:0] RangeBytes = 32'(NumWords * 4);
   localparam logic [3:0]  GntWaitC   = 4'(GntWait);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_e;

   state_e        state_q;
   logic [3:0]    wait_q;
   logic [31:0]   mem_q [NumWords];

   logic          handshake;
   logic          addr_legal;
   logic [31:0]   offset;
   logic [IdxW-1:0] idx;

   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   // Grant once the request has been held for GntWait stall cycles.
   assign data_gnt_o = data_req_i && (wait_q == GntWaitC);
   assign handshake  = data_req_i && data_gnt_o;

   // Unsigned offset; an address below BaseAddr wraps to a huge offset and
   // is rejected by the explicit lower-bound compare anyway.
   assign offset     = data_addr_i - BaseAddr;
   assign addr_legal = (data_addr_i[1:0] == 2'b00) &&
                       (data_addr_i >= BaseAddr) &&
                       (offset < RangeBytes);
   assign idx        = offset[IdxW+1:2];

   // Grant-delay FSM: count stalled request cycles, clear on handshake or withdrawal.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
      end else if (data_req_i && !data_gnt_o) begin
         state_q <= STALL;
         wait_q  <= wait_q + 4'd1;
      end else begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
      end
   end

   // Register file storage: byte-masked writes on legal write handshakes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < int'(NumWords); w++) begin
            mem_q[w] <= 32'd0;
         end
      end else if (handshake && addr_legal && data_we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Response stage: one-cycle latency, data only for legal reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= handshake;
         err_q    <= handshake && !addr_legal;
         if (handshake && addr_legal && !data_we_i) begin
            rdata_q <= mem_q[idx];
         end else begin
            rdata_q <= 32'd0;
         end
      end
   end

   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign data_err_o    = err_q;
   assign busy_o        = (state_q == STALL) || rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_vcve2_vrf_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vcve2_vrf_obi_responder
// Description : Directed self-checking bench. dut0 uses default parameters,
//               dut1 uses GntWait=3 and BaseAddr=0x1000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vcve2_vrf_obi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
   logic [3:0]  be0 = 4'h0;
   logic        gnt0, rvalid0, err0, busy0;
   logic [31:0] rdata0;

   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
   logic [3:0]  be1 = 4'h0;
   logic        gnt1, rvalid1, err1, busy1;
   logic [31:0] rdata1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vcve2_vrf_obi_responder dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(req0), .data_gnt_o(gnt0), .data_addr_i(addr0),
      .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
      .data_rvalid_o(rvalid0), .data_rdata_o(rdata0), .data_err_o(err0),
      .busy_o(busy0)
   );

   vcve2_vrf_obi_responder #(.GntWait(3), .BaseAddr(32'h0000_1000)) dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(req1), .data_gnt_o(gnt1), .data_addr_i(addr1),
      .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1),
      .data_rvalid_o(rvalid1), .data_rdata_o(rdata1), .data_err_o(err1),
      .busy_o(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(negedge clk);
   endtask

   task automatic drv0(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
      req0 = r; we0 = w; addr0 = a; be0 = b; wdata0 = d;
   endtask

   // single dut0 transaction, called at a falling edge
   task automatic x0(input string tag, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd);
      drv0(1'b1, w, a, b, d);
      nx();
      drv0(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      chk({tag, "_rvalid"}, 32'(rvalid0), 32'd1);
      chk({tag, "_err"},    32'(err0),    32'(e_err));
      chk({tag, "_rdata"},  rdata0,       e_rd);
   endtask

   // single dut1 transaction; checks the grant arrives after exactly 3 stalls
   task automatic xact1(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
      int n;
      req1 = 1'b1; we1 = w; addr1 = a; be1 = 4'hF; wdata1 = d;
      #1;
      n = 0;
      while (!gnt1 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk({tag, "_gnt"},  32'(gnt1), 32'd1);
      chk({tag, "_wait"}, 32'(n),    32'd3);
      @(negedge clk);
      req1 = 1'b0;
      #1;
      chk({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
      chk({tag, "_err"},    32'(err1),    32'(e_err));
      chk({tag, "_rdata"},  rdata1,       e_rd);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset state ----------------
      nx(); nx();
      chk("rst_rvalid", 32'(rvalid0), 32'd0);
      chk("rst_rdata",  rdata0,       32'd0);
      chk("rst_err",    32'(err0),    32'd0);
      chk("rst_busy",   32'(busy0),   32'd0);
      req0 = 1'b1; #1;
      chk("rst_gnt_follows_req", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      nx();
      rst_n = 1'b1;
      nx();

      // ---------------- write then read, same-cycle grant ----------------
      drv0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); #1;
      chk("w10_gnt", 32'(gnt0), 32'd1);
      nx();
      chk("w10_rvalid", 32'(rvalid0), 32'd1);
      chk("w10_rdata",  rdata0,       32'd0);
      chk("w10_err",    32'(err0),    32'd0);
      chk("w10_busy",   32'(busy0),   32'd1);
      drv0(1'b1, 1'b0, 32'h10, 4'h0, 32'd0); #1;
      chk("r10_gnt", 32'(gnt0), 32'd1);
      nx();
      chk("r10_rvalid", 32'(rvalid0), 32'd1);
      chk("r10_rdata",  rdata0,       32'hDEADBEEF);
      chk("r10_err",    32'(err0),    32'd0);
      drv0(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      nx();
      chk("idle_rvalid", 32'(rvalid0), 32'd0);
      chk("idle_rdata",  rdata0,       32'd0);
      chk("idle_busy",   32'(busy0),   32'd0);

      // ---------------- byte enables ----------------
      x0("w20_full", 1'b1, 32'h20, 4'hF,    32'h11223344, 1'b0, 32'd0);
      x0("w20_be5",  1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, 32'd0);
      x0("r20_a",    1'b0, 32'h20, 4'hF,    32'd0,        1'b0, 32'h11BB33DD);
      x0("w20_be0",  1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'd0);
      x0("r20_b",    1'b0, 32'h20, 4'hF,    32'd0,        1'b0, 32'h11BB33DD);

      // ---------------- errors and upper boundary ----------------
      x0("r202_mis",  1'b0, 32'h202, 4'hF, 32'd0,        1'b1, 32'd0);
      x0("r200_oob",  1'b0, 32'h200, 4'hF, 32'd0,        1'b1, 32'd0);
      x0("w12_mis",   1'b1, 32'h12,  4'hF, 32'hFFFFFFFF, 1'b1, 32'd0);
      x0("r10_keep",  1'b0, 32'h10,  4'hF, 32'd0,        1'b0, 32'hDEADBEEF);
      x0("w1fc_last", 1'b1, 32'h1FC, 4'hF, 32'h12345678, 1'b0, 32'd0);
      x0("r1fc_last", 1'b0, 32'h1FC, 4'hF, 32'd0,        1'b0, 32'h12345678);

      // ---------------- streaming after reset: storage cleared ----------------
      rst_n = 1'b0;
      nx();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drv0(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'd0);
         nx();
         chk($sformatf("stream0_rvalid%0d", i), 32'(rvalid0), 32'd1);
         chk($sformatf("stream0_rdata%0d", i),  rdata0,       32'd0);
      end
      drv0(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      nx();
      chk("stream0_end_rvalid", 32'(rvalid0), 32'd0);

      // ---------------- back-to-back ordered stream with mid-stream reset ----------------
      for (int i = 0; i < 8; i++) begin
         drv0(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'h100 + 32'(i));
         nx();
      end
      for (int i = 0; i < 4; i++) begin
         drv0(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'd0);
         nx();
         chk($sformatf("stream1_rvalid%0d", i), 32'(rvalid0), 32'd1);
         chk($sformatf("stream1_rdata%0d", i),  rdata0,       32'h100 + 32'(i));
      end
      drv0(1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(rvalid0), 32'd0);
      chk("midrst_busy",   32'(busy0),   32'd0);
      nx();
      chk("midrst_drop", 32'(rvalid0), 32'd0);
      drv0(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      rst_n = 1'b1;
      nx();
      x0("postrst_r0c", 1'b0, 32'h0C, 4'hF, 32'd0, 1'b0, 32'd0);
      x0("postrst_r1c", 1'b0, 32'h1C, 4'hF, 32'd0, 1'b0, 32'd0);

      // ---------------- GntWait=3 grant timing ----------------
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1000; be1 = 4'hF;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("gw3_gnt_c%0d", c),    32'(gnt1),    (c == 4) ? 32'd1 : 32'd0);
         chk($sformatf("gw3_busy_c%0d", c),   32'(busy1),   (c >= 2) ? 32'd1 : 32'd0);
         chk($sformatf("gw3_rvalid_c%0d", c), 32'(rvalid1), 32'd0);
         @(negedge clk);
      end
      req1 = 1'b0;
      #1;
      chk("gw3_rvalid_c5", 32'(rvalid1), 32'd1);
      chk("gw3_busy_c5",   32'(busy1),   32'd1);
      chk("gw3_err_c5",    32'(err1),    32'd0);
      @(negedge clk); #1;
      chk("gw3_busy_c6",   32'(busy1),   32'd0);
      chk("gw3_rvalid_c6", 32'(rvalid1), 32'd0);

      // withdrawal after two stalled cycles: no response
      @(negedge clk);
      req1 = 1'b1; #1;
      chk("wd_gnt_c1", 32'(gnt1), 32'd0);
      @(negedge clk); #1;
      chk("wd_gnt_c2",  32'(gnt1),  32'd0);
      chk("wd_busy_c2", 32'(busy1), 32'd1);
      req1 = 1'b0;
      @(negedge clk); #1;
      chk("wd_rvalid_a", 32'(rvalid1), 32'd0);
      chk("wd_busy_a",   32'(busy1),   32'd0);
      @(negedge clk); #1;
      chk("wd_rvalid_b", 32'(rvalid1), 32'd0);
      @(negedge clk);

      // ---------------- BaseAddr=0x1000 errors ----------------
      xact1("b_w1000",  1'b1, 32'h1000, 32'hCAFEF00D, 1'b0, 32'd0);
      xact1("b_wffc",   1'b1, 32'h0FFC, 32'h0BADBEEF, 1'b1, 32'd0);
      xact1("b_r1000",  1'b0, 32'h1000, 32'd0,        1'b0, 32'hCAFEF00D);
      xact1("b_r11fc",  1'b0, 32'h11FC, 32'd0,        1'b0, 32'd0);
      xact1("b_r1200",  1'b0, 32'h1200, 32'd0,        1'b1, 32'd0);
      xact1("b_r1002",  1'b0, 32'h1002, 32'd0,        1'b1, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vcve2_vrf_obi_responder.md
VCVE2_VRF_OBI_RESPONDER -- requirements
Module: vcve2_vrf_obi_responder

Interface
REQ-001 Parameter VLEN, default 128, vector register length in bits.
REQ-002 Parameter NumVRegs, default 32, number of vector registers stored.
REQ-003 Parameter BaseAddr, default 32'h0000_0000, byte address of word 0.
REQ-004 Parameter GntWait, default 0 (legal 0..15), request cycles before grant.
REQ-005 Derived NumWords = NumVRegs*VLEN/32 (128 at defaults); word index width = clog2(NumWords).
REQ-006 clk_i  input  1  clock, all state on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 data_req_i  input  1  OBI request from initiator.
REQ-009 data_gnt_o  output  1  OBI grant, combinational.
REQ-010 data_addr_i  input  32  byte address.
REQ-011 data_we_i  input  1  1 = write, 0 = read.
REQ-012 data_be_i  input  4  byte enables, bit n selects bits 8n+7:8n.
REQ-013 data_wdata_i  input  32  write data.
REQ-014 data_rvalid_o  output  1  response valid, registered.
REQ-015 data_rdata_o  output  32  read data, registered.
REQ-016 data_err_o  output  1  response error, registered.
REQ-017 busy_o  output  1  high while a request is stalled or a response is pending.

Function
REQ-018 Storage SHALL be NumWords x 32-bit flops, no other memory.
REQ-019 Handshake SHALL occur in a cycle where data_req_i=1 and data_gnt_o=1; address, we, be, wdata sampled that cycle.
REQ-020 Stall counter wait_q (4 bits) SHALL increment each cycle data_req_i=1 and data_gnt_o=0, clear on handshake or data_req_i=0.
REQ-021 data_gnt_o SHALL equal data_req_i AND (wait_q == GntWait); GntWait=0 gives same-cycle grant.
REQ-022 FSM states IDLE, STALL: IDLE->STALL when data_req_i=1 and no grant; STALL->IDLE on handshake or data_req_i=0 (request withdrawal clears counter, no transaction).
REQ-023 Address legal iff data_addr_i[1:0]=0, data_addr_i >= BaseAddr, and (data_addr_i-BaseAddr) < NumWords*4; index = (data_addr_i-BaseAddr)>>2.
REQ-024 Legal write handshake SHALL update only enabled bytes of the indexed word at the handshake clock edge; be=4'b0000 writes nothing, no error.
REQ-025 Legal read handshake SHALL capture the indexed word's content as held before that edge.
REQ-026 Illegal handshake SHALL not modify storage and SHALL produce an error response.
REQ-027 data_rvalid_o SHALL be high exactly the cycle after each handshake (latency 1); no rready, responses never stall.
REQ-028 Back-to-back handshakes on consecutive cycles SHALL yield consecutive rvalid cycles, in order.
REQ-029 data_rdata_o SHALL be read data for legal reads, 0 for writes and errors, 0 whenever data_rvalid_o=0.
REQ-030 data_err_o SHALL be 1 only with data_rvalid_o=1 for an illegal handshake, else 0.
REQ-031 Read handshake one cycle after a write to the same word SHALL return the written value.
REQ-032 busy_o = (state==STALL) OR data_rvalid_o.
REQ-033 Address arithmetic SHALL be 32-bit unsigned; addresses below BaseAddr SHALL not wrap into range.

Reset
REQ-034 On rst_ni=0: data_rvalid_o=0, data_rdata_o=0, data_err_o=0, wait_q=0, state=IDLE, all storage words 0; data_gnt_o then follows REQ-021 with wait_q=0.
REQ-035 Reset asserted mid-stall or with a response pending SHALL drop that response; a handshake in the reset-release cycle is processed normally.

Verification
REQ-036 GntWait=0: write 0xDEADBEEF, be=4'hF to addr 0x10, then read 0x10 next cycle -> gnt same cycle each, rvalid cycles 2 and 3, read rdata=0xDEADBEEF, err=0.
REQ-037 Byte enables: word 0x20 = 0x11223344, write 0xAABBCCDD be=4'b0101 -> subsequent read returns 0x11BB33DD.
REQ-038 GntWait=3: hold req 4 cycles -> gnt only in 4th cycle, busy_o high cycles 2-5, rvalid in 5th; withdraw req after 2 cycles -> no rvalid, wait_q=0.
REQ-039 Errors: read 0x202 (misaligned), read NumWords*4 (0x200), write BaseAddr-4 with BaseAddr=0x1000 -> rvalid with err=1, rdata=0, storage unchanged.
REQ-040 Streaming: 8 back-to-back reads of 0x00..0x1C after reset -> 8 consecutive rvalid cycles, rdata=0, in order; assert rst_ni mid-stream -> rvalid=0 next cycle, later reads return 0.
